mem_wb_skid_stage: RTL and testbench
====================================

# mem_wb_skid_stage

Parametrised MEM→WB pipeline stage with a valid/ready handshake and a two-entry skid buffer, so the write-back side can stall without a combinational ready path back into MEM. It carries the scalar, memory and matrix results with their write-back control fields. It also supports a synchronous flush and keeps a saturating count of write-back bubble cycles for performance debug.

## Interface
- XLEN, 32: scalar data width (mem_data, alu_o)
- MAT_W, 128: matrix result width
- RD_W, 5: destination register index width
- WSEL_W, 2: write-back select width
- CNT_W, 16: bubble counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous flush; drops all buffered beats
- me_valid  in  1  upstream beat valid
- me_ready  out  XLEN-independent 1  stage can accept; registered
- me_mem_data, me_alu_o  in  XLEN  upstream data
- me_matrix_o  in  MAT_W  upstream matrix result
- me_rd  in  RD_W; me_mem2reg  in  1; me_w_select  in  WSEL_W; me_rs2_r_select  in  1
- wb_valid  out  1  downstream beat valid
- wb_ready  in  1  write-back consumes beat
- wb_mem_data, wb_alu_o  out  XLEN; wb_matrix_o  out  MAT_W
- wb_rd  out  RD_W; wb_mem2reg  out  1; wb_w_select  out  WSEL_W; wb_rs2_r_select  out  1
- bubble_cnt  out  CNT_W  saturating count of bubble cycles

## Operation
- Accept when me_valid & me_ready; consume when wb_valid & wb_ready.
- Storage: main entry (drives wb_*) and skid entry; each holds a valid bit and a full payload.
- States: EMPTY (neither valid), ONE (main valid), FULL (both valid). wb_valid = state != EMPTY.
- me_ready is registered: 1 in EMPTY/ONE, 0 in FULL.
- EMPTY: accept → ONE, main ← input.
- ONE: accept & consume → ONE, main ← input; accept only → FULL, skid ← input; consume only → EMPTY; neither → hold.
- FULL: consume → ONE, main ← skid; otherwise hold. No accept is possible.
- Flush has priority over every other event. State → EMPTY, me_ready → 1, and the incoming beat in the same cycle is dropped.
- Payload registers are not cleared by flush.
- A beat presented on the flush cycle with wb_ready=1 counts as consumed.
- Bubble semantics: while wb_valid=0, wb_rd, wb_mem2reg, wb_w_select and wb_rs2_r_select are forced to 0. Data outputs hold their last value.
- bubble_cnt increments on cycles with wb_ready=1 & wb_valid=0. It saturates at 2^CNT_W−1 and is unaffected by flush.
- Ordering is strictly FIFO; no beat is duplicated or lost except by flush.

## Timing
- Reset (rst=0, asynchronous): state EMPTY, me_ready=1, wb_valid=0, all wb_* payload outputs 0, bubble_cnt=0, skid payload 0.
- Latency: a beat accepted at edge N appears on wb_* after edge N. Minimum one cycle.
- Throughput: one beat per cycle while wb_ready stays high.
- After wb_ready drops, at most one further beat is accepted (into skid); me_ready falls the following cycle.
- After wb_ready returns in FULL: main ← skid at that edge, and me_ready=1 from the next cycle.
- Reset asserted mid-transfer discards both entries immediately, regardless of handshake state.

## Structure
- Shared package mem_wb_pkg holds:
  - the state enum {EMPTY, ONE, FULL};
  - the packed payload struct typedef, parameterised by field widths via localparams matching the defaults.
- One sub-module, sat_counter (parameter W; inc, count; async active-low reset), implements bubble_cnt.
- The payload entries stay inline.

## Test plan
- Reset then idle with wb_ready=1 for 10 cycles → wb_valid=0, me_ready=1, control outputs 0, bubble_cnt=10.
- Stream alu_o=1..8 with wb_ready=1 every cycle → wb_alu_o shows 1..8 on consecutive cycles, one cycle after each accept, no gaps.
- Stream 1..4, drop wb_ready after the beat 1 accept for 3 cycles → skid holds 2 and me_ready=0. After release the order is 1,2,3,4 with no loss.
- Stage FULL (beats 5,6), assert flush together with me_valid carrying beat 7 → next cycle wb_valid=0, me_ready=1, beat 7 never appears.
- Set CNT_W=4 and run 20 bubble cycles → bubble_cnt sticks at 15.
- Assert rst low asynchronously mid-stream while FULL → outputs go to reset values before the next clk edge.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM->WB skid stage: occupancy states and the default-width payload layout.
package mem_wb_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_MAT_W  = 128;
  localparam int DEF_RD_W   = 5;
  localparam int DEF_WSEL_W = 2;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_XLEN-1:0]   mem_data;
    logic [DEF_XLEN-1:0]   alu_o;
    logic [DEF_MAT_W-1:0]  matrix_o;
    logic [DEF_RD_W-1:0]   rd;
    logic                  mem2reg;
    logic [DEF_WSEL_W-1:0] w_select;
    logic                  rs2_r_select;
  } mem_wb_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with a two-entry skid buffer; me_ready is registered so
// write-back stalls never form a combinational path back into MEM.
module mem_wb_skid_stage
  import mem_wb_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int MAT_W  = DEF_MAT_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int WSEL_W = DEF_WSEL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              me_valid,
  output logic              me_ready,
  input  logic [XLEN-1:0]   me_mem_data,
  input  logic [XLEN-1:0]   me_alu_o,
  input  logic [MAT_W-1:0]  me_matrix_o,
  input  logic [RD_W-1:0]   me_rd,
  input  logic              me_mem2reg,
  input  logic [WSEL_W-1:0] me_w_select,
  input  logic              me_rs2_r_select,

  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_mem_data,
  output logic [XLEN-1:0]   wb_alu_o,
  output logic [MAT_W-1:0]  wb_matrix_o,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_mem2reg,
  output logic [WSEL_W-1:0] wb_w_select,
  output logic              wb_rs2_r_select,

  output logic [CNT_W-1:0]  bubble_cnt
);

  // Same layout as mem_wb_payload_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]   mem_data;
    logic [XLEN-1:0]   alu_o;
    logic [MAT_W-1:0]  matrix_o;
    logic [RD_W-1:0]   rd;
    logic              mem2reg;
    logic [WSEL_W-1:0] w_select;
    logic              rs2_r_select;
  } payload_t;

  state_e   state_q, state_d;
  logic     me_ready_q;
  payload_t main_q, skid_q, in_beat;
  logic     accept, consume;
  logic     load_main_in, load_main_skid, load_skid;

  assign in_beat = '{mem_data:     me_mem_data,
                     alu_o:        me_alu_o,
                     matrix_o:     me_matrix_o,
                     rd:           me_rd,
                     mem2reg:      me_mem2reg,
                     w_select:     me_w_select,
                     rs2_r_select: me_rs2_r_select};

  assign me_ready = me_ready_q;
  assign wb_valid = (state_q != EMPTY);
  assign accept   = me_valid & me_ready_q;
  assign consume  = wb_valid & wb_ready;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // me_ready is derived from the next state so it is already low in the cycle FULL is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      me_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      me_ready_q <= (state_d != FULL);
    end
  end

  // NOTE: payload registers are reset so wb_* data is defined out of reset;
  // flush deliberately leaves them alone since only the valid state matters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_beat;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_beat;
      end
    end
  end

  // Control fields are squashed on bubbles; data fields simply hold.
  assign wb_mem_data     = main_q.mem_data;
  assign wb_alu_o        = main_q.alu_o;
  assign wb_matrix_o     = main_q.matrix_o;
  assign wb_rd           = wb_valid ? main_q.rd : '0;
  assign wb_mem2reg      = wb_valid & main_q.mem2reg;
  assign wb_w_select     = wb_valid ? main_q.w_select : '0;
  assign wb_rs2_r_select = wb_valid & main_q.rs2_r_select;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_ready & ~wb_valid),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage: a FIFO-queue model checked every cycle plus literal pins.
module tb_mem_wb_skid_stage;
  import mem_wb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         me_valid;
  logic         me_ready;
  logic [31:0]  me_mem_data, me_alu_o;
  logic [127:0] me_matrix_o;
  logic [4:0]   me_rd;
  logic         me_mem2reg;
  logic [1:0]   me_w_select;
  logic         me_rs2_r_select;
  logic         wb_valid;
  logic         wb_ready;
  logic [31:0]  wb_mem_data, wb_alu_o;
  logic [127:0] wb_matrix_o;
  logic [4:0]   wb_rd;
  logic         wb_mem2reg;
  logic [1:0]   wb_w_select;
  logic         wb_rs2_r_select;
  logic [15:0]  bubble_cnt;

  logic         me_ready4, wb_valid4, wb_mem2reg4, wb_rs2_r_select4;
  logic [31:0]  wb_mem_data4, wb_alu_o4;
  logic [127:0] wb_matrix_o4;
  logic [4:0]   wb_rd4;
  logic [1:0]   wb_w_select4;
  logic [3:0]   bubble_cnt4;

  always #5 clk = ~clk;

  mem_wb_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .me_valid(me_valid), .me_ready(me_ready),
    .me_mem_data(me_mem_data), .me_alu_o(me_alu_o), .me_matrix_o(me_matrix_o),
    .me_rd(me_rd), .me_mem2reg(me_mem2reg), .me_w_select(me_w_select),
    .me_rs2_r_select(me_rs2_r_select),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_mem_data(wb_mem_data), .wb_alu_o(wb_alu_o), .wb_matrix_o(wb_matrix_o),
    .wb_rd(wb_rd), .wb_mem2reg(wb_mem2reg), .wb_w_select(wb_w_select),
    .wb_rs2_r_select(wb_rs2_r_select),
    .bubble_cnt(bubble_cnt)
  );

  mem_wb_skid_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .me_valid(me_valid), .me_ready(me_ready4),
    .me_mem_data(me_mem_data), .me_alu_o(me_alu_o), .me_matrix_o(me_matrix_o),
    .me_rd(me_rd), .me_mem2reg(me_mem2reg), .me_w_select(me_w_select),
    .me_rs2_r_select(me_rs2_r_select),
    .wb_valid(wb_valid4), .wb_ready(wb_ready),
    .wb_mem_data(wb_mem_data4), .wb_alu_o(wb_alu_o4), .wb_matrix_o(wb_matrix_o4),
    .wb_rd(wb_rd4), .wb_mem2reg(wb_mem2reg4), .wb_w_select(wb_w_select4),
    .wb_rs2_r_select(wb_rs2_r_select4),
    .bubble_cnt(bubble_cnt4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int v);
    logic [31:0] x;
    x               = v;
    me_valid        = 1'b1;
    me_alu_o        = x;
    me_mem_data     = x * 32'd3 + 32'h100;
    me_matrix_o     = {x, ~x, x ^ 32'h5a5a_5a5a, 32'hdead_0000 | x};
    me_rd           = x[4:0];
    me_mem2reg      = x[0];
    me_w_select     = x[2:1];
    me_rs2_r_select = x[3];
  endtask

  // Model: the stage is a FIFO of at most two beats; the head is what write-back sees.
  mem_wb_payload_t mq[$];
  mem_wb_payload_t last_head;
  bit              m_ready;
  int              m_cnt16, m_cnt4;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      last_head = '0;
      m_ready   = 1'b1;
      m_cnt16   = 0;
      m_cnt4    = 0;
    end else begin
      bit had, acc, cons;
      mem_wb_payload_t b;
      had  = (mq.size() > 0);
      acc  = me_valid && m_ready;
      cons = had && wb_ready;
      if (wb_ready && !had) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      b = '{mem_data: me_mem_data, alu_o: me_alu_o, matrix_o: me_matrix_o, rd: me_rd,
            mem2reg: me_mem2reg, w_select: me_w_select, rs2_r_select: me_rs2_r_select};
      if (flush) begin
        mq.delete();
      end else begin
        if (cons) void'(mq.pop_front());
        if (acc) mq.push_back(b);
      end
      m_ready = (mq.size() < 2);
      if (mq.size() > 0) last_head = mq[0];
    end
  end

  always @(negedge clk) begin
    mem_wb_payload_t h;
    bit v;
    v = (mq.size() > 0);
    h = v ? mq[0] : last_head;
    check("wb_valid", wb_valid, v);
    check("me_ready", me_ready, m_ready);
    check("wb_alu_o", wb_alu_o, h.alu_o);
    check("wb_mem_data", wb_mem_data, h.mem_data);
    check("wb_matrix_o", wb_matrix_o, h.matrix_o);
    check("wb_rd", wb_rd, v ? h.rd : 5'd0);
    check("wb_mem2reg", wb_mem2reg, v ? h.mem2reg : 1'b0);
    check("wb_w_select", wb_w_select, v ? h.w_select : 2'd0);
    check("wb_rs2_r_select", wb_rs2_r_select, v ? h.rs2_r_select : 1'b0);
    check("bubble_cnt", bubble_cnt, m_cnt16);
    check("bubble_cnt4", bubble_cnt4, m_cnt4);
    check("dut4_wb_valid", wb_valid4, v);
    check("dut4_wb_alu_o", wb_alu_o4, h.alu_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  int          next_beat;
  bit          acc;
  logic [31:0] got[$];

  initial begin
    rst = 1'b0; flush = 1'b0; wb_ready = 1'b0; me_valid = 1'b0;
    drive(0); me_valid = 1'b0;

    // Reset then 10 idle cycles with wb_ready high.
    repeat (2) @(negedge clk);
    check("reset_wb_valid", wb_valid, 1'b0);
    check("reset_me_ready", me_ready, 1'b1);
    rst = 1'b1; wb_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_bubble_10", bubble_cnt, 16'd10);
    check("idle_wb_rd", wb_rd, 5'd0);

    // Back-to-back stream of 1..8.
    for (int i = 1; i <= 8; i++) begin
      drive(i);
      @(negedge clk);
      check("stream_alu", wb_alu_o, i);
      check("stream_valid", wb_valid, 1'b1);
    end
    me_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Stall wb_ready for three cycles right after beat 1 is accepted.
    next_beat = 1;
    got.delete();
    for (int cyc = 0; cyc < 30 && got.size() < 4; cyc++) begin
      wb_ready = !(cyc >= 1 && cyc <= 3);
      if (next_beat <= 4) drive(next_beat);
      else me_valid = 1'b0;
      if (cyc == 2) begin
        check("skid_me_ready_low", me_ready, 1'b0);
        check("skid_main_is_1", wb_alu_o, 32'd1);
        check("skid_holds_2", dut.skid_q.alu_o, 32'd2);
      end
      if (wb_valid && wb_ready) got.push_back(wb_alu_o);
      acc = me_valid && me_ready;
      @(negedge clk);
      if (acc) next_beat++;
    end
    me_valid = 1'b0;
    check("skid_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("skid_order", (i < got.size()) ? got[i] : 32'hffff_ffff, i + 1);
    end
    repeat (2) @(negedge clk);

    // Fill to FULL with 5,6, then flush while beat 7 is presented.
    wb_ready = 1'b0; drive(5);
    @(negedge clk); drive(6);
    @(negedge clk);
    check("pre_flush_full", me_ready, 1'b0);
    flush = 1'b1; wb_ready = 1'b1; drive(7);
    @(negedge clk);
    flush = 1'b0; me_valid = 1'b0;
    check("flush_wb_valid", wb_valid, 1'b0);
    check("flush_me_ready", me_ready, 1'b1);
    check("flush_data_hold", wb_alu_o, 32'd5);
    repeat (3) begin
      @(negedge clk);
      check("beat7_absent", wb_valid, 1'b0);
    end

    // Asynchronous reset while FULL (beats 9,10), between clock edges.
    wb_ready = 1'b0; drive(9);
    @(negedge clk); drive(10);
    @(negedge clk);
    check("pre_reset_full", me_ready, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_wb_valid", wb_valid, 1'b0);
    check("async_me_ready", me_ready, 1'b1);
    check("async_alu", wb_alu_o, 32'd0);
    check("async_matrix", wb_matrix_o, 128'd0);
    check("async_bubble", bubble_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b1; me_valid = 1'b0; wb_ready = 1'b1;

    // 20 bubble cycles: 4-bit counter saturates, 16-bit one keeps counting.
    repeat (20) @(negedge clk);
    check("sat_cnt4", bubble_cnt4, 4'd15);
    check("sat_cnt16", bubble_cnt, 16'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
